memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 158 +++++++++++++++
 tb/tb_memory_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Request/response memory endpoint: pops link packets, serves masked writes and word reads from a local RAM.
// Optional malformed-packet counter on err_count when MEM_RESPONDER_ERR_CNT_EN is defined.
module memory_responder #(
    parameter  int DATA_WIDTH_BYTE = 4,
    parameter  int ADDR_WIDTH_BYTE = 4,
    parameter  int RAM_ADDR_BITS   = 10,
    localparam int SEND_BYTE       = DATA_WIDTH_BYTE + ADDR_WIDTH_BYTE + DATA_WIDTH_BYTE/8 + 1,
    localparam int PW              = 8*SEND_BYTE
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          receivable,
    input  logic [PW-1:0] recv_data,
    input  logic [4:0]    recv_length,
    output logic          recv_flag,
    input  logic          sendable,
    output logic          send_flag,
    output logic [PW-1:0] send_data,
    output logic [4:0]    send_length,
    output logic          busy,
    output logic [7:0]    err_count
);

    // state  | meaning
    // IDLE   | waiting for a request packet
    // DECODE | classify latched packet; writes commit here, reads launch RAM access
    // READ   | capture RAM output word
    // RESP   | wait for sendable, then push the read response
    typedef enum logic [1:0] {IDLE, DECODE, READ, RESP} state_t;

    localparam int DW    = 8*DATA_WIDTH_BYTE;
    localparam int AW    = 8*ADDR_WIDTH_BYTE;
    localparam int OFS   = $clog2(DATA_WIDTH_BYTE);
    localparam int DEPTH = 1 << RAM_ADDR_BITS;
    localparam logic [4:0] LEN_RD   = 5'(ADDR_WIDTH_BYTE + 1);
    localparam logic [4:0] LEN_WR   = 5'(SEND_BYTE);
    localparam logic [4:0] LEN_RESP = 5'(DATA_WIDTH_BYTE);

    state_t r_state, w_next;
    logic [PW-1:0] r_pkt;
    logic [4:0]    r_len;
    logic [DW-1:0] r_rdata, r_word;
    logic [DW-1:0] r_mem [DEPTH];
    logic          r_recv_flag, r_send_flag;
    logic [PW-1:0] r_send_data;
    logic [4:0]    r_send_length;

    logic w_is_rd, w_is_wr, w_pop, w_wr_en, w_rd_en, w_send, w_bad;
    logic [AW-1:0]              w_addr;
    logic [RAM_ADDR_BITS-1:0]   w_idx;
    logic [DATA_WIDTH_BYTE-1:0] w_mask;
    logic [DW-1:0]              w_wdata;

    // The flag bit must agree with the length, otherwise the packet is dropped.
    assign w_is_rd = (r_len == LEN_RD) && !r_pkt[AW];
    assign w_is_wr = (r_len == LEN_WR) && r_pkt[DW+AW+DATA_WIDTH_BYTE];
    assign w_addr  = w_is_wr ? r_pkt[DW +: AW] : r_pkt[0 +: AW];
    assign w_idx   = w_addr[OFS +: RAM_ADDR_BITS];
    assign w_mask  = r_pkt[DW+AW +: DATA_WIDTH_BYTE];
    assign w_wdata = r_pkt[0 +: DW];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_pop   = 1'b0;
        w_wr_en = 1'b0;
        w_rd_en = 1'b0;
        w_send  = 1'b0;
        w_bad   = 1'b0;
        case (r_state)
            IDLE: begin
                if (receivable) begin
                    w_pop  = 1'b1;
                    w_next = DECODE;
                end
            end
            DECODE: begin
                if (w_is_wr) begin
                    w_wr_en = 1'b1;
                    w_next  = IDLE;
                end else if (w_is_rd) begin
                    w_rd_en = 1'b1;
                    w_next  = READ;
                end else begin
                    w_bad  = 1'b1;
                    w_next = IDLE;
                end
            end
            READ: w_next = RESP;
            RESP: begin
                if (sendable) begin
                    w_send = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pkt         <= '0;
            r_len         <= '0;
            r_word        <= '0;
            r_recv_flag   <= 1'b0;
            r_send_flag   <= 1'b0;
            r_send_data   <= '0;
            r_send_length <= '0;
        end else begin
            r_recv_flag <= w_pop;
            r_send_flag <= w_send;
            if (w_pop) begin
                r_pkt <= recv_data;
                r_len <= recv_length;
            end
            if (r_state == READ) r_word <= r_rdata;
            if (w_send) begin
                r_send_data   <= {{(PW-DW){1'b0}}, r_word};
                r_send_length <= LEN_RESP;
            end
        end
    end

    // RAM is deliberately outside the reset domain so contents survive RST.
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            for (int b = 0; b < DATA_WIDTH_BYTE; b++) begin
                if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
        if (w_rd_en) r_rdata <= r_mem[w_idx];
    end

`ifdef MEM_RESPONDER_ERR_CNT_EN
    logic [7:0] r_err_count;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                               r_err_count <= 8'd0;
        else if (w_bad && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end
    assign err_count = r_err_count;
`else
    assign err_count = 8'd0;
`endif

    logic w_unused;
    assign w_unused = ^{r_pkt, w_addr, w_bad};

    assign recv_flag   = r_recv_flag;
    assign send_flag   = r_send_flag;
    assign send_data   = r_send_data;
    assign send_length = r_send_length;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder at default parameters: vector table, read-response scoreboard, corner sequences.
module tb_memory_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        receivable = 1'b0;
    logic [71:0] recv_data = '0;
    logic [4:0]  recv_length = '0;
    logic        recv_flag;
    logic        sendable = 1'b1;
    logic        send_flag;
    logic [71:0] send_data;
    logic [4:0]  send_length;
    logic        busy;
    logic [7:0]  err_count;

    memory_responder dut (
        .CLK(CLK), .RST(RST),
        .receivable(receivable), .recv_data(recv_data), .recv_length(recv_length), .recv_flag(recv_flag),
        .sendable(sendable), .send_flag(send_flag), .send_data(send_data), .send_length(send_length),
        .busy(busy), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  len;
        logic [71:0] pkt;
        logic        bad;
        logic        resp;
        logic [31:0] rd;
    } vec_t;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_recv = 0;
    int          exp_recv = 0;
    int          n_send = 0;
    int          exp_send = 0;
    int          exp_errc = 0;
    logic [31:0] sb_q[$];
    logic        mon_en = 1'b1;
    vec_t        v[16];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        return {3'b000, 1'b1, m, a, d};
    endfunction

    function automatic logic [71:0] rd(input logic [31:0] a);
        return {39'd0, 1'b0, a};
    endfunction

    always @(negedge CLK) begin
        if (recv_flag) n_recv++;
        if (send_flag && mon_en) begin
            n_send++;
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_send_flag actual=1 required=0");
            end else begin
                logic [31:0] e;
                e = sb_q.pop_front();
                chk("send_data", send_data, {40'd0, e});
                chk("send_length", {67'd0, send_length}, 72'd4);
            end
        end
    end

    task automatic drive(input logic [4:0] len, input logic [71:0] pkt);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (busy) chk("drive_idle_timeout", 72'd1, 72'd0);
        receivable  = 1'b1;
        recv_length = len;
        recv_data   = pkt;
        @(negedge CLK);
        receivable = 1'b0;
        exp_recv++;
        chk("recv_flag_pulse", {71'd0, recv_flag}, 72'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge CLK);
        while ((busy || sb_q.size() != 0) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (busy || sb_q.size() != 0) chk("wait_done_timeout", 72'd1, 72'd0);
    endtask

    task automatic bump_err();
`ifdef MEM_RESPONDER_ERR_CNT_EN
        if (exp_errc < 255) exp_errc++;
`endif
    endtask

    initial begin
        v[0]  = '{5'd9,  wr(32'h10,  32'hDEADBEEF, 4'hF), 1'b0, 1'b0, 32'h0};
        v[1]  = '{5'd5,  rd(32'h10),                      1'b0, 1'b1, 32'hDEADBEEF};
        v[2]  = '{5'd9,  wr(32'h10,  32'h00001234, 4'h3), 1'b0, 1'b0, 32'h0};
        v[3]  = '{5'd5,  rd(32'h10),                      1'b0, 1'b1, 32'hDEAD1234};
        v[4]  = '{5'd5,  rd(32'h1010),                    1'b0, 1'b1, 32'hDEAD1234};
        v[5]  = '{5'd7,  wr(32'h10,  32'h0, 4'hF),        1'b1, 1'b0, 32'h0};
        v[6]  = '{5'd9,  {4'b0000, 4'hF, 32'h10, 32'hFFFFFFFF}, 1'b1, 1'b0, 32'h0};
        v[7]  = '{5'd5,  rd(32'h10) | (72'd1 << 32),      1'b1, 1'b0, 32'h0};
        v[8]  = '{5'd9,  wr(32'hFFC, 32'h11223344, 4'hF), 1'b0, 1'b0, 32'h0};
        v[9]  = '{5'd9,  wr(32'hFFC, 32'hAABBCCDD, 4'hA), 1'b0, 1'b0, 32'h0};
        v[10] = '{5'd5,  rd(32'hFFC),                     1'b0, 1'b1, 32'hAA22CC44};
        v[11] = '{5'd5,  rd(32'hFFF),                     1'b0, 1'b1, 32'hAA22CC44};
        v[12] = '{5'd9,  wr(32'h10,  32'hFFFFFFFF, 4'h0), 1'b0, 1'b0, 32'h0};
        v[13] = '{5'd5,  rd(32'h10),                      1'b0, 1'b1, 32'hDEAD1234};
        v[14] = '{5'd0,  rd(32'h10),                      1'b1, 1'b0, 32'h0};
        v[15] = '{5'd31, wr(32'h10,  32'h0, 4'hF),        1'b1, 1'b0, 32'h0};

        #1 RST = 1'b1;
        #2;
        chk("rst_recv_flag",   {71'd0, recv_flag}, 72'd0);
        chk("rst_send_flag",   {71'd0, send_flag}, 72'd0);
        chk("rst_busy",        {71'd0, busy},      72'd0);
        chk("rst_err_count",   {64'd0, err_count}, 72'd0);
        chk("rst_send_data",   send_data,          72'd0);
        chk("rst_send_length", {67'd0, send_length}, 72'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 16; i++) begin
            if (v[i].resp) begin
                sb_q.push_back(v[i].rd);
                exp_send++;
            end
            if (v[i].bad) bump_err();
            drive(v[i].len, v[i].pkt);
            wait_done();
            chk($sformatf("err_count_v%0d", i), {64'd0, err_count}, exp_errc[71:0]);
        end

        // Read latency: response pulse appears exactly at the fourth negedge after drive.
        sb_q.push_back(32'hDEAD1234);
        exp_send++;
        drive(5'd5, rd(32'h10));
        @(negedge CLK); chk("lat_n2_send_flag", {71'd0, send_flag}, 72'd0);
        @(negedge CLK); chk("lat_n3_send_flag", {71'd0, send_flag}, 72'd0);
        @(negedge CLK); chk("lat_n4_send_flag", {71'd0, send_flag}, 72'd1);
        wait_done();
        repeat (3) @(negedge CLK);
        chk("send_data_hold", send_data, {40'd0, 32'hDEAD1234});

        // Backpressure with receivable held high throughout.
        sendable = 1'b0;
        sb_q.push_back(32'hAA22CC44);
        exp_send++;
        exp_recv++;
        receivable  = 1'b1;
        recv_length = 5'd5;
        recv_data   = rd(32'hFFC);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("bp_recv_flag", {71'd0, recv_flag}, (i == 0) ? 72'd1 : 72'd0);
            chk("bp_busy",      {71'd0, busy},      72'd1);
            chk("bp_send_flag", {71'd0, send_flag}, 72'd0);
        end
        sendable   = 1'b1;
        receivable = 1'b0;
        @(negedge CLK); chk("bp_release_send_flag", {71'd0, send_flag}, 72'd1);
        @(negedge CLK); chk("bp_single_send_flag",  {71'd0, send_flag}, 72'd0);
        wait_done();

        // Reset while waiting in RESP abandons the response.
        sendable = 1'b0;
        drive(5'd5, rd(32'h10));
        @(negedge CLK);
        @(negedge CLK);
        chk("resp_busy_before_rst", {71'd0, busy}, 72'd1);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_busy",        {71'd0, busy},        72'd0);
        chk("mid_rst_send_flag",   {71'd0, send_flag},   72'd0);
        chk("mid_rst_send_data",   send_data,            72'd0);
        chk("mid_rst_send_length", {67'd0, send_length}, 72'd0);
        chk("mid_rst_err_count",   {64'd0, err_count},   72'd0);
        exp_errc = 0;
        @(negedge CLK);
        RST      = 1'b0;
        sendable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("post_rst_no_send", {71'd0, send_flag}, 72'd0);
        end
        sb_q.push_back(32'hDEAD1234);
        exp_send++;
        drive(5'd5, rd(32'h10));
        wait_done();
        sb_q.push_back(32'hAA22CC44);
        exp_send++;
        drive(5'd5, rd(32'hFFC));
        wait_done();

        chk("recv_flag_count", exp_recv[71:0] & 72'hFFFF, n_recv[71:0] & 72'hFFFF);
        chk("send_flag_count", exp_send[71:0] & 72'hFFFF, n_send[71:0] & 72'hFFFF);
        chk("scoreboard_empty", {40'd0, 32'(sb_q.size())}, 72'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
